// File: rtl/btn_conditioner_pkg.sv
// Shared types and widths for the push-button conditioning stage.
package btn_conditioner_pkg;

    typedef enum logic [1:0] {
        S_LO      = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HI      = 2'd2,
        S_WAIT_LO = 2'd3
    } btn_state_t;

    localparam int MS_CNT_W   = 8;
    localparam int PRESCALE_W = 16;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchronizer, millisecond debounce FSM and edge pulses.
module btn_debounce_ch
    import btn_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_MS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic ms_tick,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic press_next,
    output logic level_next
);

    localparam logic [MS_CNT_W-1:0] LAST_MS = MS_CNT_W'(DEBOUNCE_MS - 1);

    logic                btn_meta;
    logic                btn_sync;
    btn_state_t          state;
    logic [MS_CNT_W-1:0] ms_cnt;
    logic                done;
    logic                release_next;

    // press/release decisions are exported one cycle early so the top can register its summary flags in step
    assign done         = ms_tick && (ms_cnt == LAST_MS);
    assign press_next   = (state == S_WAIT_HI) && btn_sync && done;
    assign release_next = (state == S_WAIT_LO) && !btn_sync && done;
    assign level_next   = press_next ? 1'b1 : (release_next ? 1'b0 : btn_level);

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta    <= 1'b0;
            btn_sync    <= 1'b0;
            state       <= S_LO;
            ms_cnt      <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_meta    <= btn_raw;
            btn_sync    <= btn_meta;
            btn_level   <= level_next;
            btn_press   <= press_next;
            btn_release <= release_next;
            case (state)
                S_LO: begin
                    if (btn_sync) begin
                        state  <= S_WAIT_HI;
                        ms_cnt <= '0;
                    end
                end
                S_WAIT_HI: begin
                    if (!btn_sync) begin
                        state  <= S_LO;
                        ms_cnt <= '0;
                    end else if (ms_tick) begin
                        if (ms_cnt == LAST_MS) state <= S_HI;
                        else                   ms_cnt <= ms_cnt + MS_CNT_W'(1);
                    end
                end
                S_HI: begin
                    if (!btn_sync) begin
                        state  <= S_WAIT_LO;
                        ms_cnt <= '0;
                    end
                end
                S_WAIT_LO: begin
                    if (btn_sync) begin
                        state  <= S_HI;
                        ms_cnt <= '0;
                    end else if (ms_tick) begin
                        if (ms_cnt == LAST_MS) state <= S_LO;
                        else                   ms_cnt <= ms_cnt + MS_CNT_W'(1);
                    end
                end
                default: state <= S_LO;
            endcase
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Button conditioning top: shared millisecond prescaler, per-button debounce channels,
// and a registered lowest-index press encoder.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int NUM_BTN     = 4,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                ticks_per_milli,
    input  logic [NUM_BTN-1:0]         btn_raw,
    output logic [NUM_BTN-1:0]         btn_level,
    output logic [NUM_BTN-1:0]         btn_press,
    output logic [NUM_BTN-1:0]         btn_release,
    output logic                       press_valid,
    output logic [$clog2(NUM_BTN)-1:0] press_id,
    output logic                       btn_any
);

    localparam int ID_W = $clog2(NUM_BTN);

    logic [PRESCALE_W-1:0] pre_cnt;
    logic [PRESCALE_W-1:0] pre_term;
    logic                  ms_tick;
    logic [NUM_BTN-1:0]    press_next;
    logic [NUM_BTN-1:0]    level_next;
    logic [ID_W-1:0]       id_next;

    // Terminal compare uses the live input, so a shrink below the current count runs on to 16-bit wrap
    assign pre_term = (ticks_per_milli == '0) ? '0 : ticks_per_milli - PRESCALE_W'(1);
    assign ms_tick  = (pre_cnt == pre_term);

    always_ff @(posedge clk) begin
        if (rst)          pre_cnt <= '0;
        else if (ms_tick) pre_cnt <= '0;
        else              pre_cnt <= pre_cnt + PRESCALE_W'(1);
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_MS(DEBOUNCE_MS)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .ms_tick    (ms_tick),
            .btn_raw    (btn_raw[g]),
            .btn_level  (btn_level[g]),
            .btn_press  (btn_press[g]),
            .btn_release(btn_release[g]),
            .press_next (press_next[g]),
            .level_next (level_next[g])
        );
    end

    always_comb begin
        id_next = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (press_next[i]) id_next = ID_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            press_valid <= 1'b0;
            press_id    <= '0;
            btn_any     <= 1'b0;
        end else begin
            press_valid <= |press_next;
            press_id    <= id_next;
            btn_any     <= |level_next;
        end
    end

endmodule
